bam_driver: RTL and testbench
=============================

Name: bam_driver

Overview:
- Memory-mapped Binary Angle Modulation (BAM) peripheral on the data bus.
- Responds to the per-register write strobes produced by the bus address decoder: DCYCLE at word 131, CONFIG at word 132.
- Generates CHANNELS BAM outputs and exposes register readback for the read-data mux.
- Duty updates are double-buffered and applied only at frame boundaries, so a frame is never torn.

Parameters:
- CHANNELS, 4, number of BAM outputs. CHANNELS*BITS must equal 32.
- BITS, 8, duty resolution per channel. Frame length is 2^BITS-1 units.
- PRESC_W, 16, prescaler width, taken from CONFIG[31:16].

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_dcycle_we  in  1  write strobe for the DCYCLE register
- i_config_we  in  1  write strobe for the CONFIG register
- i_wdata  in  32  bus write data
- o_dcycle  out  32  readback of the pending DCYCLE register
- o_config  out  32  readback of the CONFIG register
- o_bam  out  CHANNELS  BAM outputs; channel c duty is DCYCLE[BITS*c+BITS-1:BITS*c]
- o_busy  out  1  high while in the RUN state
- o_frame_done  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset (synchronous, i_rst=1 at an edge):
  - pending, active and CONFIG are cleared to 0; state = IDLE.
  - All counters are cleared.
  - o_bam=0, o_busy=0, o_frame_done=0.
  - Reset takes priority over strobes and over an in-progress frame. The output returns to the reset values on the edge after i_rst is sampled.
- CONFIG fields:
  - bit0 EN.
  - bit1 INV (output polarity).
  - [31:16] P (prescaler).
  - All other bits are stored and read back unchanged.
- Register writes:
  - i_dcycle_we at an edge: pending <= i_wdata. Never writes active directly.
  - i_config_we at an edge: CONFIG <= i_wdata.
  - Both strobes high at once: both registers update.
- Unit tick: pre_cnt counts 0..P. A tick occurs when pre_cnt>=P, and pre_cnt then returns to 0. One unit therefore lasts P+1 clocks. Using >= means that lowering P mid-count never stalls the counter.
- Slots:
  - slot runs 0..BITS-1.
  - Slot k lasts 2^k ticks, counted by slot_cnt.
  - After the last tick of slot BITS-1, slot returns to 0.
  - Frame length = (2^BITS-1)*(P+1) clocks.
- State machine, IDLE -> RUN:
  - Trigger: the edge where the CONFIG write has i_wdata[0]=1 while in IDLE.
  - On that edge: active <= pending; slot, slot_cnt and pre_cnt <= 0.
  - The RUN cycle after that edge is frame clock 0.
- State machine, RUN -> IDLE:
  - Trigger: the edge where a CONFIG write has i_wdata[0]=0.
  - This applies immediately, even mid-frame; counters are cleared and no frame_done pulse is emitted.
- A CONFIG write with EN=1 while in RUN does not restart the frame. New P and INV values take effect immediately.
- Output:
  - o_bam[c] = (RUN ? active[c][slot] : 0) ^ INV.
  - It is a function of registered state only, so there is no combinational path from the inputs.
  - In IDLE every o_bam bit equals INV.
- Frame wrap:
  - Condition: tick in the last slot and the final slot_cnt.
  - On that edge: active <= pending, and o_frame_done=1 for the following single cycle.
  - A DCYCLE write on that same edge is not seen by this load: active takes the old pending value, and the new value applies at the next wrap.
- Channel high time per frame = duty*(P+1) clocks, LSB slot first. Duty 0 gives an output constantly at INV. Duty 2^BITS-1 gives an output constantly at !INV.
- o_busy = (state==RUN).
- Readback: o_dcycle = pending and o_config = CONFIG, each valid the cycle after the write edge.

Test Plan:
1. Reset, then DCYCLE=0x00000001 and CONFIG=0x00000001 (P=0) -> o_bam[0]=1 for frame clock 0 only within each 255-clock frame; o_frame_done pulses every 255 clocks; o_bam[3:1]=0.
2. DCYCLE=0x000000FF,0x80 in ch1 (0x000080FF), P=0 -> o_bam[0] constant 1; o_bam[1] high on frame clocks 127..254, exactly 128 clocks.
3. CONFIG=0x00020001 (P=2), DCYCLE=0x03 -> ch0 high on frame clocks 0..8 (9 clocks); frame length 765 clocks.
4. Mid-frame DCYCLE write 0x10 while running 0x01 -> the current frame is unchanged; o_bam[0] switches to the slot-4 pattern (frame clocks 15..30) only after the next o_frame_done. Repeat with the write on the wrap edge -> the change is applied one frame later.
5. CONFIG=0x00000003 (INV) with duty 0 -> o_bam all 1. Then write CONFIG=0x00000002 mid-frame -> o_busy=0 and o_bam=4'hF on the next cycle, with no frame_done pulse.
6. Assert i_rst for one cycle mid-frame, with a concurrent i_config_we -> CONFIG, pending and o_dcycle read 0; o_bam=0, o_busy=0; no further frame_done pulses.

Source files
------------

// File: rtl/bam_driver.sv
// bam_driver: memory-mapped Binary Angle Modulation peripheral.
//
// Generates CHANNELS BAM outputs from a 32-bit duty register. Each frame is
// split into BITS slots; slot k lasts 2^k prescaled units. Channel c's output
// is high during slot k when bit k of its duty field is set. Duty writes go to
// a pending register and are copied into the active register only when a
// frame starts or wraps, so a frame is never torn.
//
// Ports:
//   i_clk         system clock
//   i_rst         synchronous reset, active-high
//   i_dcycle_we   write strobe for DCYCLE (pending duty register)
//   i_config_we   write strobe for CONFIG (bit0 EN, bit1 INV, [31:16] P)
//   i_wdata       bus write data
//   o_dcycle      readback of pending DCYCLE
//   o_config      readback of CONFIG
//   o_bam         BAM outputs, channel c duty = DCYCLE[BITS*c +: BITS]
//   o_busy        high while in RUN
//   o_frame_done  one-cycle pulse following each frame wrap
module bam_driver #(
    parameter int CHANNELS = 4,
    parameter int BITS     = 8,
    parameter int PRESC_W  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_dcycle_we,
    input  logic                i_config_we,
    input  logic [31:0]         i_wdata,
    output logic [31:0]         o_dcycle,
    output logic [31:0]         o_config,
    output logic [CHANNELS-1:0] o_bam,
    output logic                o_busy,
    output logic                o_frame_done
);

    localparam int SLOT_W = (BITS > 1) ? $clog2(BITS) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         pending_q, pending_d;
    logic [31:0]         active_q, active_d;
    logic [31:0]         config_q, config_d;
    logic [PRESC_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [BITS-1:0]     slot_cnt_q, slot_cnt_d;
    logic                frame_done_q, frame_done_d;

    logic [PRESC_W-1:0]  presc;
    logic                inv;
    logic                start;
    logic                stop;
    logic                tick;
    logic                slot_end;
    logic                last_slot;
    logic [CHANNELS-1:0] ch_bit;

    assign presc = config_q[16 +: PRESC_W];
    assign inv   = config_q[1];

    // EN is taken from the write data itself, so the transition happens on
    // the same edge as the CONFIG write.
    assign start = (state_q == ST_IDLE) && i_config_we && i_wdata[0];
    assign stop  = (state_q == ST_RUN) && i_config_we && !i_wdata[0];

    // >= rather than == so lowering P below the current count still ticks.
    assign tick      = (pre_cnt_q >= presc);
    assign slot_end  = (slot_cnt_q == ((BITS'(1) << slot_q) - BITS'(1)));
    assign last_slot = (slot_q == SLOT_W'(BITS - 1));

    // Duty bit of each channel for the current slot.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [BITS-1:0] duty;
        assign duty      = active_q[c*BITS +: BITS];
        assign ch_bit[c] = duty[slot_q];
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (stop)  state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
    end

    // Output logic: registered state only, no path from the inputs.
    always_comb begin
        o_busy = (state_q == ST_RUN);
        for (int c = 0; c < CHANNELS; c++) begin
            o_bam[c] = ((state_q == ST_RUN) & ch_bit[c]) ^ inv;
        end
    end

    // Datapath next-state: registers, prescaler, slot sequencing.
    always_comb begin
        pending_d    = i_dcycle_we ? i_wdata : pending_q;
        config_d     = i_config_we ? i_wdata : config_q;
        active_d     = active_q;
        pre_cnt_d    = pre_cnt_q;
        slot_d       = slot_q;
        slot_cnt_d   = slot_cnt_q;
        frame_done_d = 1'b0;

        if (start) begin
            // Old pending value: a DCYCLE write on this edge is not yet visible.
            active_d   = pending_q;
            pre_cnt_d  = '0;
            slot_d     = '0;
            slot_cnt_d = '0;
        end else if (stop) begin
            pre_cnt_d  = '0;
            slot_d     = '0;
            slot_cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            if (tick) begin
                pre_cnt_d = '0;
                if (slot_end) begin
                    slot_cnt_d = '0;
                    if (last_slot) begin
                        slot_d       = '0;
                        active_d     = pending_q;
                        frame_done_d = 1'b1;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end else begin
                    slot_cnt_d = slot_cnt_q + BITS'(1);
                end
            end else begin
                pre_cnt_d = pre_cnt_q + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q    <= '0;
            active_q     <= '0;
            config_q     <= '0;
            pre_cnt_q    <= '0;
            slot_q       <= '0;
            slot_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            active_q     <= active_d;
            config_q     <= config_d;
            pre_cnt_q    <= pre_cnt_d;
            slot_q       <= slot_d;
            slot_cnt_q   <= slot_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_dcycle     = pending_q;
    assign o_config     = config_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_bam_driver.sv
// Bench for bam_driver (CHANNELS=4, BITS=8, PRESC_W=16).
// Expected outputs come from a frame-clock level model: position within the
// frame is a single counter, and the slot is recovered from the unit index.
module tb_bam_driver;

  localparam int W = 70;

  // clock / reset
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_rst = 1'b0;
  logic        i_dcycle_we = 1'b0;
  logic        i_config_we = 1'b0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_dcycle;
  logic [31:0] o_config;
  logic [3:0]  o_bam;
  logic        o_busy;
  logic        o_frame_done;

  bam_driver #(.CHANNELS(4), .BITS(8), .PRESC_W(16)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_dcycle_we  (i_dcycle_we),
    .i_config_we  (i_config_we),
    .i_wdata      (i_wdata),
    .o_dcycle     (o_dcycle),
    .o_config     (o_config),
    .o_bam        (o_bam),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  logic [31:0] m_pend = '0;
  logic [31:0] m_act = '0;
  logic [31:0] m_cfg = '0;
  logic        m_run = 1'b0;
  int          m_fc = 0;

  // per-window counters
  int n_fd, n_b0, n_b1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int frame_len(input logic [31:0] cfg);
    return 255 * (int'(cfg[31:16]) + 1);
  endfunction

  // Slot k covers units 2^k-1 .. 2^(k+1)-2.
  function automatic logic [3:0] model_bam(input logic [31:0] act, input int fc,
                                           input logic [31:0] cfg, input logic run);
    int u;
    int s;
    logic [3:0] b;
    u = fc / (int'(cfg[31:16]) + 1);
    s = 0;
    while (s < 7 && ((1 << (s + 1)) - 1) <= u) s++;
    for (int c = 0; c < 4; c++) begin
      b[c] = (run ? act[c*8 + s] : 1'b0) ^ cfg[1];
    end
    return b;
  endfunction

  // driver: one clock edge with the given inputs, then compare
  task automatic step(input logic rst, input logic dwe, input logic cwe, input logic [31:0] wd);
    logic fd;
    logic [W-1:0] got;
    i_rst = rst;
    i_dcycle_we = dwe;
    i_config_we = cwe;
    i_wdata = wd;
    @(posedge i_clk);
    fd = 1'b0;
    if (rst) begin
      m_pend = '0; m_cfg = '0; m_act = '0; m_run = 1'b0; m_fc = 0;
    end else begin
      if (m_run) begin
        if (cwe && !wd[0]) begin
          m_run = 1'b0; m_fc = 0;
        end else if (m_fc == frame_len(m_cfg) - 1) begin
          m_fc = 0; m_act = m_pend; fd = 1'b1;
        end else begin
          m_fc++;
        end
      end else if (cwe && wd[0]) begin
        m_run = 1'b1; m_fc = 0; m_act = m_pend;
      end
      if (dwe) m_pend = wd;
      if (cwe) m_cfg = wd;
    end
    exp_q.push_back({m_pend, m_cfg, model_bam(m_act, m_fc, m_cfg, m_run), m_run, fd});
    #1;
    i_rst = 1'b0;
    i_dcycle_we = 1'b0;
    i_config_we = 1'b0;
    i_wdata = '0;
    got = {o_dcycle, o_config, o_bam, o_busy, o_frame_done};
    check($sformatf("cyc%0d", cyc), got, exp_q.pop_front());
    cyc++;
    if (o_frame_done) n_fd++;
    if (o_bam[0]) n_b0++;
    if (o_bam[1]) n_b1++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic count_frame(input int n);
    n_fd = 0; n_b0 = 0; n_b1 = 0;
    idle(n);
  endtask

  // Advance until the last clock of the current frame has been observed.
  task automatic run_to_wrap();
    for (int i = 0; i < 2000; i++) begin
      if (m_run && m_fc == frame_len(m_cfg) - 1) break;
      step(1'b0, 1'b0, 1'b0, 32'h0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] rp;
    logic        rinv;
    // reset state
    step(1'b1, 1'b0, 1'b0, 32'h0);
    idle(2);

    // 1: duty 1 on ch0, P=0
    step(1'b0, 1'b1, 1'b0, 32'h0000_0001);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0001);
    count_frame(765);
    check("t1_frame_done_count", W'(n_fd), W'(3));
    check("t1_ch0_high_count", W'(n_b0), W'(3));

    // 2: ch0 full, ch1 0x80 (applied at next wrap)
    step(1'b0, 1'b1, 1'b0, 32'h0000_80FF);
    run_to_wrap();
    count_frame(255);
    check("t2_ch0_high_count", W'(n_b0), W'(255));
    check("t2_ch1_high_count", W'(n_b1), W'(128));
    check("t2_frame_done_count", W'(n_fd), W'(1));

    // 3: P=2, duty 3
    step(1'b0, 1'b0, 1'b1, 32'h0000_0000);
    step(1'b0, 1'b1, 1'b0, 32'h0000_0003);
    step(1'b0, 1'b0, 1'b1, 32'h0002_0001);
    run_to_wrap();
    count_frame(765);
    check("t3_ch0_high_count", W'(n_b0), W'(9));
    check("t3_frame_done_count", W'(n_fd), W'(1));

    // 4: mid-frame write, then write on the wrap edge
    step(1'b0, 1'b0, 1'b1, 32'h0000_0000);
    step(1'b0, 1'b1, 1'b0, 32'h0000_0001);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0001);
    idle(50);
    step(1'b0, 1'b1, 1'b0, 32'h0000_0010);
    run_to_wrap();
    count_frame(255);
    check("t4_slot4_high_count", W'(n_b0), W'(16));
    run_to_wrap();
    step(1'b0, 1'b1, 1'b0, 32'h0000_0001);
    count_frame(254);
    check("t4_wrap_edge_old_duty", W'(n_b0), W'(16));
    count_frame(255);
    check("t4_wrap_edge_new_duty", W'(n_b0), W'(1));

    // 5: INV with duty 0, then disable mid-frame
    step(1'b0, 1'b0, 1'b1, 32'h0000_0000);
    step(1'b0, 1'b1, 1'b0, 32'h0000_0000);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0003);
    count_frame(255);
    check("t5_inv_ch0_high_count", W'(n_b0), W'(255));
    idle(20);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0002);
    count_frame(300);
    check("t5_idle_frame_done_count", W'(n_fd), W'(0));
    check("t5_idle_ch0_high_count", W'(n_b0), W'(300));

    // 6: reset mid-frame with a concurrent CONFIG write
    step(1'b0, 1'b1, 1'b0, 32'h1234_5678);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0001);
    idle(100);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    count_frame(300);
    check("t6_frame_done_count", W'(n_fd), W'(0));
    check("t6_ch0_high_count", W'(n_b0), W'(0));

    // random: duty writes and INV/other-bit changes while running
    for (int r = 0; r < 4; r++) begin
      rp = 16'($urandom_range(0, 2));
      rinv = 1'($urandom_range(0, 1));
      step(1'b0, 1'b0, 1'b1, 32'h0000_0000);
      step(1'b0, 1'b1, 1'b0, $urandom);
      step(1'b0, 1'b0, 1'b1, {rp, 14'h0, rinv, 1'b1});
      for (int i = 0; i < 400; i++) begin
        case ($urandom_range(0, 19))
          0: step(1'b0, 1'b1, 1'b0, $urandom);
          1: step(1'b0, 1'b0, 1'b1, {rp, 14'($urandom), 1'($urandom_range(0, 1)), 1'b1});
          default: step(1'b0, 1'b0, 1'b0, 32'h0);
        endcase
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
